// File: rtl/uart_baud_scheduler_if.sv
// ---------------------------------------------------------------------------
// uart_baud_scheduler_if
// Baud-rate configuration channel into the UART baud scheduler.
//   baud_sel   [2:0]   rate code (0=2400 .. 6=115200, 7=reserved/custom)
//   sel_valid          baud_sel is valid
//   sel_ready          scheduler can accept a new code
//   cfg_busy           change accepted, waiting for a TX bit boundary
//   custom_div [CNT_W] divisor used for code 7 (only with UART_BAUD_CUSTOM_EN)
// master = configuration source, slave = scheduler.
// ---------------------------------------------------------------------------
interface uart_baud_scheduler_if #(
    parameter int CNT_W = 16
);
    logic [2:0] baud_sel;
    logic       sel_valid;
    logic       sel_ready;
    logic       cfg_busy;
`ifdef UART_BAUD_CUSTOM_EN
    logic [CNT_W-1:0] custom_div;

    modport master (output baud_sel, sel_valid, custom_div, input sel_ready, cfg_busy);
    modport slave  (input baud_sel, sel_valid, custom_div, output sel_ready, cfg_busy);
`else
    modport master (output baud_sel, sel_valid, input sel_ready, cfg_busy);
    modport slave  (input baud_sel, sel_valid, output sel_ready, cfg_busy);
`endif
endinterface

// File: rtl/uart_baud_scheduler.sv
// ---------------------------------------------------------------------------
// uart_baud_scheduler
// Shared baud timing for the UART: one programmable oversample divider feeds
// a TX bit tick, RX oversample ticks and an RX mid-bit strobe. Baud changes
// arrive over a valid/ready channel and are applied only on a TX bit
// boundary so a frame in flight keeps its timing.
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   cfg             baud configuration channel (uart_baud_scheduler_if.slave)
//   tx_en, rx_en    TX / RX engines active
//   rx_resync       one-cycle pulse on a detected RX start edge
//   tx_tick         one pulse per TX bit period
//   rx_tick         one pulse per oversample period while rx_en
//   rx_mid          pulse at the RX mid-bit sample point
//
// Optional macro UART_BAUD_CUSTOM_EN: code 7 latches cfg.custom_div
// (clamped to a minimum of 2) instead of falling back to 19200.
// ---------------------------------------------------------------------------
module uart_baud_scheduler #(
    parameter int CLK_HZ     = 50000000,
    parameter int OVERSAMPLE = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_baud_scheduler_if.slave  cfg,
    input  logic                  tx_en,
    input  logic                  rx_en,
    input  logic                  rx_resync,
    output logic                  tx_tick,
    output logic                  rx_tick,
    output logic                  rx_mid
);
    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OVERSAMPLE - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OVERSAMPLE / 2 - 1);

    // Rounded divisor: clocks per oversample period for a given baud.
    function automatic logic [CNT_W-1:0] calc_div(input longint baud);
        return CNT_W'((longint'(CLK_HZ) + baud * OVERSAMPLE / 2) / (baud * OVERSAMPLE));
    endfunction

    localparam logic [CNT_W-1:0] DIV0 = calc_div(2400);
    localparam logic [CNT_W-1:0] DIV1 = calc_div(4800);
    localparam logic [CNT_W-1:0] DIV2 = calc_div(9600);
    localparam logic [CNT_W-1:0] DIV3 = calc_div(19200);
    localparam logic [CNT_W-1:0] DIV4 = calc_div(38400);
    localparam logic [CNT_W-1:0] DIV5 = calc_div(57600);
    localparam logic [CNT_W-1:0] DIV6 = calc_div(115200);

    typedef enum logic [1:0] {STOP, RUN, PEND} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] act_div_q, act_div_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [PH_W-1:0]  tx_phase_q, tx_phase_d;
    logic [PH_W-1:0]  rx_phase_q, rx_phase_d;
    logic             ready_q;

    logic [CNT_W-1:0] code7_div, new_div, cnt_run;
    logic [PH_W-1:0]  tx_run, rx_run;
    logic             any_en, os_tick, handshake, apply;

    // ---- divisor lookup for the code on the channel ----
`ifdef UART_BAUD_CUSTOM_EN
    assign code7_div = (cfg.custom_div < CNT_W'(2)) ? CNT_W'(2) : cfg.custom_div;
`else
    assign code7_div = DIV3;
`endif

    always_comb begin
        case (cfg.baud_sel)
            3'd0:    new_div = DIV0;
            3'd1:    new_div = DIV1;
            3'd2:    new_div = DIV2;
            3'd3:    new_div = DIV3;
            3'd4:    new_div = DIV4;
            3'd5:    new_div = DIV5;
            3'd6:    new_div = DIV6;
            default: new_div = code7_div;
        endcase
    end

    // ---- tick generation ----
    assign any_en    = tx_en | rx_en;
    assign os_tick   = (state_q != STOP) && (div_cnt_q == act_div_q - CNT_W'(1));
    assign tx_tick   = os_tick & tx_en & (tx_phase_q == PH_LAST);
    assign rx_tick   = os_tick & rx_en;
    assign rx_mid    = rx_tick & (rx_phase_q == PH_MID);

    // ready_q keeps sel_ready low while reset is held and for the release edge.
    assign cfg.sel_ready = ready_q & (state_q != PEND);
    assign cfg.cfg_busy  = (state_q == PEND);
    assign handshake     = cfg.sel_valid & cfg.sel_ready;

    // Swap divisors only at a TX bit boundary (or whenever TX is idle on an
    // oversample boundary), or immediately if both engines went idle.
    assign apply = (os_tick & ((tx_phase_q == PH_LAST) | ~tx_en)) | ~any_en;

    // Free-running next values; the FSM overrides them when clearing.
    assign cnt_run = os_tick ? '0 : div_cnt_q + CNT_W'(1);
    assign tx_run  = !tx_en ? '0 :
                     os_tick ? ((tx_phase_q == PH_LAST) ? '0 : tx_phase_q + PH_W'(1)) :
                     tx_phase_q;
    // rx_resync beats an oversample increment in the same cycle.
    assign rx_run  = (!rx_en || rx_resync) ? '0 :
                     os_tick ? ((rx_phase_q == PH_LAST) ? '0 : rx_phase_q + PH_W'(1)) :
                     rx_phase_q;

    // ---- FSM ----
    always_comb begin
        state_d    = state_q;
        act_div_d  = act_div_q;
        pend_div_d = pend_div_q;
        div_cnt_d  = cnt_run;
        tx_phase_d = tx_run;
        rx_phase_d = rx_run;
        case (state_q)
            STOP: begin
                div_cnt_d  = '0;
                tx_phase_d = '0;
                rx_phase_d = '0;
                // A code accepted together with an enable rising is in
                // place before the first count.
                if (handshake) act_div_d = new_div;
                if (any_en)    state_d   = RUN;
            end
            RUN: begin
                if (!any_en) begin
                    div_cnt_d  = '0;
                    tx_phase_d = '0;
                    rx_phase_d = '0;
                    // Nothing in flight, so an accepted code applies at once.
                    if (handshake) act_div_d = new_div;
                    state_d = STOP;
                end else if (handshake) begin
                    pend_div_d = new_div;
                    state_d    = PEND;
                end
            end
            PEND: begin
                if (apply) begin
                    act_div_d  = pend_div_q;
                    div_cnt_d  = '0;
                    tx_phase_d = '0;
                    rx_phase_d = '0;
                    state_d    = any_en ? RUN : STOP;
                end
            end
            default: state_d = STOP;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= STOP;
            act_div_q  <= DIV3;
            pend_div_q <= DIV3;
            div_cnt_q  <= '0;
            tx_phase_q <= '0;
            rx_phase_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            act_div_q  <= act_div_d;
            pend_div_q <= pend_div_d;
            div_cnt_q  <= div_cnt_d;
            tx_phase_q <= tx_phase_d;
            rx_phase_q <= rx_phase_d;
            ready_q    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_uart_baud_scheduler.sv
// ---------------------------------------------------------------------------
// tb_uart_baud_scheduler
// Self-checking bench for uart_baud_scheduler. Expected tick cycles come from
// a closed-form model: once counting starts at cycle run_start with divisor d,
// oversample ticks land on every d-th cycle, TX ticks on every 16th of those,
// and RX mid-bit on the 8th (mod 16) tick after the last RX phase reference.
// ---------------------------------------------------------------------------
module tb_uart_baud_scheduler;
    localparam int OS = 16;

    logic clk, reset, tx_en, rx_en, rx_resync;
    logic tx_tick, rx_tick, rx_mid;

    uart_baud_scheduler_if #(.CNT_W(16)) cfg_if ();

    uart_baud_scheduler #(.CLK_HZ(50000000), .OVERSAMPLE(OS), .CNT_W(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .cfg       (cfg_if),
        .tx_en     (tx_en),
        .rx_en     (rx_en),
        .rx_resync (rx_resync),
        .tx_tick   (tx_tick),
        .rx_tick   (rx_tick),
        .rx_mid    (rx_mid)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int div_tbl [7] = '{1302, 651, 326, 163, 81, 54, 27};

    // reference model state
    int run_start, m_div, rx_ref;
    bit m_tx, m_rx;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int n_os(input int c);
        if (c < run_start) return 0;
        return (c - run_start + 1) / m_div;
    endfunction

    function automatic bit os_at(input int c);
        return (c >= run_start) && (((c - run_start + 1) % m_div) == 0);
    endfunction

    function automatic bit exp_tx(input int c);
        return m_tx && os_at(c) && ((n_os(c) % OS) == 0);
    endfunction

    function automatic bit exp_rx(input int c);
        return m_rx && os_at(c);
    endfunction

    function automatic bit exp_mid(input int c);
        return exp_rx(c) && (((n_os(c) - n_os(rx_ref)) % OS) == OS / 2);
    endfunction

    task automatic go_stop();
        @(negedge clk);
        tx_en = 0; rx_en = 0; rx_resync = 0; cfg_if.sel_valid = 0;
        m_tx = 0; m_rx = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++;
        if ({tx_tick, rx_tick, rx_mid, cfg_if.cfg_busy} !== 4'b0000) begin
            $display("FAIL reset_outputs got %b want 0000", {tx_tick, rx_tick, rx_mid, cfg_if.cfg_busy});
            fails++;
        end
        reset = 0;
        @(negedge clk);
        tests++;
        if ({cfg_if.sel_ready, cfg_if.cfg_busy} !== 2'b10) begin
            $display("FAIL reset_release ready/busy got %b want 10", {cfg_if.sel_ready, cfg_if.cfg_busy});
            fails++;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if ({tx_tick, rx_tick, rx_mid} !== 3'b000) begin
                $display("FAIL stop_idle cyc=%0d ticks got %b want 000", cyc, {tx_tick, rx_tick, rx_mid});
                fails++;
                break;
            end
        end
    endtask

    task automatic test_tx_default();
        int k, c, first;
        @(negedge clk);
        tx_en = 1; k = cyc;
        run_start = k + 1; m_div = 163; m_tx = 1; m_rx = 0; rx_ref = k;
        first = -1;
        for (int i = 0; i < 2 * OS * 163 + 20; i++) begin
            @(negedge clk);
            c = cyc;
            tests++;
            if ({tx_tick, rx_tick, rx_mid} !== {exp_tx(c), exp_rx(c), exp_mid(c)}) begin
                $display("FAIL tx_default cyc=%0d got %b want %b", c,
                         {tx_tick, rx_tick, rx_mid}, {exp_tx(c), exp_rx(c), exp_mid(c)});
                fails++;
                break;
            end
            if (tx_tick && first < 0) first = c;
        end
        tests++;
        if (first !== k + 2608) begin
            $display("FAIL tx_first_tick got %0d want %0d", first - k, 2608);
            fails++;
        end
    endtask

    task automatic test_rx_resync();
        int k, c, p, s, len, t1, want_mid, got_mid;
        go_stop();
        s = $urandom_range(3, 6);
        // code accepted in the same cycle both engines start
        cfg_if.baud_sel = 3'(s); cfg_if.sel_valid = 1; tx_en = 1; rx_en = 1; k = cyc;
        run_start = k + 1; m_div = div_tbl[s]; m_tx = 1; m_rx = 1; rx_ref = k;
        p = k + 500 + $urandom_range(0, 1000);
        len = (p - k) + 2 * OS * m_div + 40;
        t1 = run_start - 1 + ((p - run_start + 1) / m_div + 1) * m_div;
        want_mid = t1 + (OS / 2 - 1) * m_div;
        got_mid = -1;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            c = cyc;
            tests++;
            if ({tx_tick, rx_tick, rx_mid} !== {exp_tx(c), exp_rx(c), exp_mid(c)}) begin
                $display("FAIL rx_resync sel=%0d cyc=%0d got %b want %b", s, c,
                         {tx_tick, rx_tick, rx_mid}, {exp_tx(c), exp_rx(c), exp_mid(c)});
                fails++;
                break;
            end
            if (rx_mid && c > p && got_mid < 0) got_mid = c;
            cfg_if.sel_valid = 0;
            rx_resync = (c == p);
            if (c == p) rx_ref = p;
        end
        rx_resync = 0;
        tests++;
        if (got_mid !== want_mid) begin
            $display("FAIL rx_mid_after_resync got %0d want %0d", got_mid, want_mid);
            fails++;
        end
    endtask

    task automatic test_baud_change();
        int k, h, ns, nd, t_apply, endc, c, last_tick, gap;
        bit busy_e;
        go_stop();
        cfg_if.baud_sel = 3; cfg_if.sel_valid = 1; tx_en = 1; k = cyc;
        run_start = k + 1; m_div = 163; m_tx = 1; m_rx = 0; rx_ref = k;
        h  = k + 1 + $urandom_range(300, 2000);
        ns = $urandom_range(4, 6);
        nd = div_tbl[ns];
        t_apply = run_start - 1 + ((h - run_start + 1) / (OS * 163) + 1) * OS * 163;
        endc = t_apply + 2 * OS * nd + 20;
        last_tick = -1; gap = -1;
        do begin
            @(negedge clk);
            c = cyc;
            if (c == t_apply + 1) begin
                run_start = c; m_div = nd;
            end
            busy_e = (c > h) && (c <= t_apply);
            tests++;
            if ({tx_tick, cfg_if.cfg_busy, cfg_if.sel_ready} !== {exp_tx(c), busy_e, !busy_e}) begin
                $display("FAIL baud_change sel=%0d cyc=%0d tick/busy/ready got %b want %b", ns, c,
                         {tx_tick, cfg_if.cfg_busy, cfg_if.sel_ready}, {exp_tx(c), busy_e, !busy_e});
                fails++;
                break;
            end
            if (tx_tick && c > t_apply) begin
                if (last_tick >= 0 && gap < 0) gap = c - last_tick;
                last_tick = c;
            end
            // a different code held while pending must be ignored
            cfg_if.sel_valid = (c == h) || (c > h && c < h + 4);
            cfg_if.baud_sel  = (c == h) ? 3'(ns) : 3'd0;
        end while (c < endc);
        cfg_if.sel_valid = 0;
        tests++;
        if (gap !== OS * nd) begin
            $display("FAIL new_tx_period got %0d want %0d", gap, OS * nd);
            fails++;
        end
    endtask

    task automatic test_stop_slow();
        int k, c, first;
        go_stop();
        cfg_if.baud_sel = 0; cfg_if.sel_valid = 1;
        @(negedge clk);
        cfg_if.sel_valid = 0; tx_en = 1; k = cyc;
        run_start = k + 1; m_div = 1302; m_tx = 1; m_rx = 0; rx_ref = k;
        first = -1;
        for (int i = 0; i < 20832 + 20; i++) begin
            @(negedge clk);
            c = cyc;
            tests++;
            if ({tx_tick, cfg_if.cfg_busy} !== {exp_tx(c), 1'b0}) begin
                $display("FAIL stop_slow cyc=%0d tick/busy got %b want %b", c,
                         {tx_tick, cfg_if.cfg_busy}, {exp_tx(c), 1'b0});
                fails++;
                break;
            end
            if (tx_tick && first < 0) first = c;
        end
        tests++;
        if (first !== k + 20832) begin
            $display("FAIL slow_first_tick got %0d want %0d", first - k, 20832);
            fails++;
        end
    endtask

    task automatic test_reset_pend();
        int k, c;
        go_stop();
        cfg_if.baud_sel = 3; cfg_if.sel_valid = 1; tx_en = 1; rx_en = 1;
        @(negedge clk);
        cfg_if.sel_valid = 0;
        repeat ($urandom_range(100, 1000)) @(negedge clk);
        cfg_if.baud_sel = 3'($urandom_range(4, 6)); cfg_if.sel_valid = 1;
        @(negedge clk);
        cfg_if.sel_valid = 0;
        tests++;
        if (cfg_if.cfg_busy !== 1'b1) begin
            $display("FAIL pend_busy got %b want 1", cfg_if.cfg_busy);
            fails++;
        end
        #2 reset = 1;
        #1;
        tests++;
        if ({tx_tick, rx_tick, rx_mid, cfg_if.cfg_busy} !== 4'b0000) begin
            $display("FAIL reset_in_pend got %b want 0000", {tx_tick, rx_tick, rx_mid, cfg_if.cfg_busy});
            fails++;
        end
        repeat (2) @(negedge clk);
        reset = 0; k = cyc;
        run_start = k + 1; m_div = 163; m_tx = 1; m_rx = 1; rx_ref = k;
        for (int i = 0; i < OS * 163 + 20; i++) begin
            @(negedge clk);
            c = cyc;
            tests++;
            if ({tx_tick, rx_tick, rx_mid, cfg_if.cfg_busy, cfg_if.sel_ready} !==
                {exp_tx(c), exp_rx(c), exp_mid(c), 1'b0, 1'b1}) begin
                $display("FAIL after_reset cyc=%0d got %b want %b", c,
                         {tx_tick, rx_tick, rx_mid, cfg_if.cfg_busy, cfg_if.sel_ready},
                         {exp_tx(c), exp_rx(c), exp_mid(c), 1'b0, 1'b1});
                fails++;
                break;
            end
        end
    endtask

    task automatic test_code7();
        int k, c, d, cust, ncase;
`ifdef UART_BAUD_CUSTOM_EN
        ncase = 3;
`else
        ncase = 1;
`endif
        for (int n = 0; n < ncase; n++) begin
            go_stop();
            cust = (n == 0) ? 10 : (n == 1) ? 0 : $urandom_range(2, 50);
`ifdef UART_BAUD_CUSTOM_EN
            d = (cust < 2) ? 2 : cust;
            cfg_if.custom_div = 16'(cust);
`else
            d = 163;
`endif
            cfg_if.baud_sel = 7; cfg_if.sel_valid = 1; tx_en = 1; k = cyc;
            run_start = k + 1; m_div = d; m_tx = 1; m_rx = 0; rx_ref = k;
            for (int i = 0; i < 2 * OS * d + 10; i++) begin
                @(negedge clk);
                c = cyc;
                tests++;
                if (tx_tick !== exp_tx(c)) begin
                    $display("FAIL code7 cust=%0d cyc=%0d tx_tick got %b want %b", cust, c, tx_tick, exp_tx(c));
                    fails++;
                    break;
                end
                cfg_if.sel_valid = 0;
`ifdef UART_BAUD_CUSTOM_EN
                // latched at handshake, later changes must not matter
                cfg_if.custom_div = 16'($urandom_range(0, 200));
`endif
            end
        end
    endtask

    initial begin
        reset = 1; tx_en = 0; rx_en = 0; rx_resync = 0;
        cfg_if.baud_sel = 0; cfg_if.sel_valid = 0;
`ifdef UART_BAUD_CUSTOM_EN
        cfg_if.custom_div = 0;
`endif
        m_tx = 0; m_rx = 0; run_start = 0; m_div = 163; rx_ref = 0;
        test_reset();
        test_tx_default();
        test_rx_resync();
        test_baud_change();
        test_stop_slow();
        test_reset_pend();
        test_code7();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_baud_scheduler.md
Name: uart_baud_scheduler

Overview:
Baud-timing controller for the UART. It owns a single programmable oversample divider and shares it between the TX and RX engines. It issues a TX bit tick, RX oversample ticks and an RX mid-bit strobe. Runtime baud changes use a valid/ready handshake and take effect only on a TX bit boundary, so a frame in flight is never corrupted.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
OVERSAMPLE, 16, RX oversample ticks per bit; even, at least 4
CNT_W, 16, divider counter width; must hold the largest divisor

Ports:
clk  input  1  system clock
reset  input  1  reset, asynchronous, active-high
baud_sel  input  3  rate code: 0=2400, 1=4800, 2=9600, 3=19200, 4=38400, 5=57600, 6=115200, 7=reserved (see Optional Feature)
sel_valid  input  1  baud_sel valid
sel_ready  output  1  scheduler can accept a new baud_sel
tx_en  input  1  TX engine active
rx_en  input  1  RX engine active
rx_resync  input  1  one-cycle pulse on detected RX start edge
tx_tick  output  1  one-cycle pulse per TX bit period
rx_tick  output  1  one-cycle pulse per oversample period while rx_en
rx_mid  output  1  one-cycle pulse at RX mid-bit sample point
cfg_busy  output  1  baud change accepted, not yet applied

Behaviour:
- Divisor table:
  - div[k] = (CLK_HZ + baud_k*OVERSAMPLE/2) / (baud_k*OVERSAMPLE), integer, computed as constants.
  - Defaults: 1302, 651, 326, 163, 81, 54, 27.
- Active divisor register act_div:
  - Reset value is div[3] (19200).
  - Code 7 without the feature maps to div[3].
- div_cnt, shared oversample counter:
  - Counts 0..act_div-1.
  - Internal os_tick is high on the cycle div_cnt==act_div-1; div_cnt wraps to 0 on that cycle.
- tx_phase, 0..OVERSAMPLE-1:
  - Advances on os_tick while tx_en.
  - Held at 0 when tx_en=0.
  - tx_tick = os_tick & tx_en & (tx_phase==OVERSAMPLE-1).
  - Result: first tx_tick is OVERSAMPLE*act_div cycles after tx_en rises, from STOP.
- rx_phase, 0..OVERSAMPLE-1:
  - Advances on os_tick while rx_en; held at 0 when rx_en=0.
  - rx_tick = os_tick & rx_en.
  - rx_mid = rx_tick & (rx_phase==OVERSAMPLE/2-1).
- rx_resync:
  - Forces rx_phase to 0 on the next edge; this overrides an os_tick increment in the same cycle.
  - Does not touch div_cnt or tx_phase; TX is never disturbed by RX.
- All tick outputs are combinational from registered state, with zero added latency.
- FSM:
  - STOP: counters held at 0; no ticks; sel_ready=1.
    - Handshake (sel_valid & sel_ready) loads act_div on the next edge; stay in STOP.
    - tx_en|rx_en -> RUN.
  - RUN: counters run; sel_ready=1.
    - Both enables low -> STOP, clearing div_cnt and phases.
    - Handshake -> PEND, latching the code into pend_div.
  - PEND: sel_ready=0, cfg_busy=1; counters keep running on the old act_div.
    - Apply condition: (os_tick & (tx_phase==OVERSAMPLE-1 | ~tx_en)) or both enables low.
    - On apply: act_div<=pend_div, div_cnt<=0, phases<=0.
    - After apply: -> RUN if any enable is high, else -> STOP.
    - A tx_tick coinciding with the apply cycle is still issued.
- Simultaneous events:
  - sel_valid together with the enable rising in STOP: the new divisor applies before the first count.
  - rx_resync on the apply cycle: rx_phase ends at 0.
  - sel_valid in PEND: ignored, since sel_ready=0; the source must hold it.
- Reset at any time, including mid-PEND:
  - State=STOP, act_div=div[3], pending change discarded.
  - All outputs 0 except sel_ready=1 from the first clock after reset release.

Optional Feature:
- Macro: UART_BAUD_CUSTOM_EN.
- Defined:
  - Adds input custom_div [CNT_W-1:0].
  - Code 7 latches custom_div at handshake time as the divisor.
  - A latched value below 2 is clamped to 2.
- Undefined:
  - Port absent; code 7 = div[3].

Test Plan:
- Reset release, tx_en=1, baud_sel untouched -> os_tick every 163 cycles, first tx_tick at cycle 2608 and every 2608 after; rx_tick=0 with rx_en=0.
- rx_en=1, rx_resync pulse at cycle 1000 -> rx_mid at 1000+7*163 rounded to the next os_tick boundary, then every 2608 cycles; tx_tick timing unchanged.
- In RUN at 19200, handshake baud_sel=6 mid-bit -> cfg_busy=1, sel_ready=0 until the next tx_tick; then tx_tick period becomes 432 cycles.
- Handshake in STOP with sel=0, then tx_en=1 -> first tx_tick after 20832 cycles; cfg_busy never asserts.
- Reset asserted during PEND -> act_div back to 163, cfg_busy=0, all ticks stop, sel_ready=1 after release.
- With UART_BAUD_CUSTOM_EN: sel=7, custom_div=10 -> tx_tick every 160 cycles; custom_div=0 -> every 32 cycles.
